// File: rtl/drum_pkg.sv
// Shared definitions for the DRUM approximate multiply-accumulate block.
// Holds the default widths, the pipeline depth and the helper that sizes
// the per-operand shift fields.
package drum_pkg;

    localparam int DEF_N      = 8;
    localparam int DEF_M      = 8;
    localparam int DEF_K      = 6;
    localparam int DEF_ACC_W  = 24;
    localparam int NUM_STAGES = 3;

    // Bits needed to hold a shift of 0 .. (width - k); never less than 1.
    function automatic int shift_w(input int width, input int k);
        int w;
        w = $clog2(width - k + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/drum_operand.sv
// One DRUM operand path: magnitude, leading-one detection, truncation to a
// K-bit mantissa and the matching left-shift amount. Purely combinational;
// the caller registers the results.
module drum_operand
    import drum_pkg::*;
#(
    parameter int W  = DEF_N,
    parameter int K  = DEF_K,
    parameter int SW = shift_w(W, K)
) (
    input  logic [W-1:0]  x,
    input  logic          signed_mode,
    output logic [K-1:0]  mant,
    output logic [SW-1:0] shift,
    output logic          neg
);

    logic [W-1:0] mag;
    int           lead;
    int           sh_int;

    // A negative operand is folded to its one's-complement magnitude.
    assign neg = signed_mode & x[W-1];

    // Find the leading one and keep the K bits below it, forcing the LSB to 1
    // so the dropped tail is replaced by its expected midpoint.
    // NOTE: every variable assigned here gets a value before any condition,
    // so no path can leave one unassigned and imply a latch.
    always_comb begin
        mag    = neg ? ~x : x;
        lead   = 0;
        sh_int = 0;
        mant   = mag[K-1:0];
        shift  = '0;
        for (int i = 0; i < W; i++) begin
            if (mag[i]) lead = i;
        end
        if (lead >= K) begin
            sh_int = lead - K + 1;
            mant   = K'((mag >> sh_int) | W'(1));
            shift  = SW'(sh_int);
        end
    end

endmodule

// File: rtl/drum_mac.sv
// DRUM approximate multiply-accumulate, three-stage valid/ready pipeline:
//   S1 operand magnitude, leading-one detection, truncation
//   S2 K x K mantissa multiply
//   S3 shift, sign restore, accumulate into the output register
// Optional build macro DRUM_MAC_SAT_EN: saturate the accumulator on
// overflow instead of wrapping modulo 2^ACC_W.
module drum_mac
    import drum_pkg::*;
#(
    parameter int N     = DEF_N,
    parameter int M     = DEF_M,
    parameter int K     = DEF_K,
    parameter int ACC_W = DEF_ACC_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_a,
    input  logic [M-1:0]     in_b,
    input  logic             in_signed,
    input  logic             in_acc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N+M-1:0]   out_prod,
    output logic [ACC_W-1:0] out_acc,
    output logic             out_ovf
);

    localparam int P_W  = N + M;
    localparam int MP_W = 2 * K;
    localparam int SW_A = shift_w(N, K);
    localparam int SW_B = shift_w(M, K);
    localparam int SH_W = shift_w(N + M - K, K);

    logic            advance;

    logic [K-1:0]    mant_a, mant_b;
    logic [SW_A-1:0] sh_a;
    logic [SW_B-1:0] sh_b;
    logic            neg_a, neg_b;

    logic            s1_valid, s1_inv, s1_signed, s1_acc;
    logic [K-1:0]    s1_mant_a, s1_mant_b;
    logic [SH_W-1:0] s1_shift;

    logic            s2_valid, s2_inv, s2_signed, s2_acc;
    logic [MP_W-1:0] s2_mprod;
    logic [SH_W-1:0] s2_shift;

    logic [P_W-1:0]   prod_sh, prod_fin;
    logic [ACC_W-1:0] ext, acc_nxt;
    logic [ACC_W:0]   sum_w;
    logic             ovf_now;

    // The whole pipeline moves together whenever the output slot is free.
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    drum_operand #(.W(N), .K(K), .SW(SW_A)) u_op_a (
        .x           (in_a),
        .signed_mode (in_signed),
        .mant        (mant_a),
        .shift       (sh_a),
        .neg         (neg_a)
    );

    drum_operand #(.W(M), .K(K), .SW(SW_B)) u_op_b (
        .x           (in_b),
        .signed_mode (in_signed),
        .mant        (mant_b),
        .shift       (sh_b),
        .neg         (neg_b)
    );

    // S1: capture truncated mantissas, combined shift and the sample flags.
    // NOTE: state is updated with <= so each stage samples its predecessor's
    // pre-edge value; = here would let data race through several stages.
    // NOTE: only the valid bit is reset; payload registers are qualified by
    // it, so their contents after reset never matter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
        end else if (advance) begin
            s1_valid  <= in_valid;
            s1_mant_a <= mant_a;
            s1_mant_b <= mant_b;
            s1_shift  <= SH_W'(sh_a) + SH_W'(sh_b);
            s1_inv    <= neg_a ^ neg_b;
            s1_signed <= in_signed;
            s1_acc    <= in_acc;
        end
    end

    // S2: small K x K multiply.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
        end else if (advance) begin
            s2_valid  <= s1_valid;
            s2_mprod  <= MP_W'(s1_mant_a) * MP_W'(s1_mant_b);
            s2_shift  <= s1_shift;
            s2_inv    <= s1_inv;
            s2_signed <= s1_signed;
            s2_acc    <= s1_acc;
        end
    end

    // S3 datapath: scale the product, restore its sign, extend and add.
    always_comb begin
        prod_sh  = P_W'(s2_mprod) << s2_shift;
        prod_fin = s2_inv ? ~prod_sh : prod_sh;
        if (s2_signed) begin
            ext = ACC_W'($signed(prod_fin));
        end else begin
            ext = ACC_W'(prod_fin);
        end
        sum_w = {1'b0, out_acc} + {1'b0, ext};
        if (s2_signed) begin
            ovf_now = s2_acc && (out_acc[ACC_W-1] == ext[ACC_W-1])
                             && (sum_w[ACC_W-1] != out_acc[ACC_W-1]);
        end else begin
            ovf_now = s2_acc && sum_w[ACC_W];
        end
        acc_nxt = s2_acc ? sum_w[ACC_W-1:0] : ext;
`ifdef DRUM_MAC_SAT_EN
        // Signed overflow needs both addends on the same side, so the sign
        // of the new term gives the direction; unsigned can only run high.
        if (ovf_now) begin
            if (s2_signed) begin
                acc_nxt = ext[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                                       : {1'b0, {(ACC_W-1){1'b1}}};
            end else begin
                acc_nxt = '1;
            end
        end
`endif
    end

    // S3 register: output slot; bubbles leave the accumulator untouched.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_prod  <= '0;
            out_acc   <= '0;
            out_ovf   <= 1'b0;
        end else if (advance) begin
            out_valid <= s2_valid;
            if (s2_valid) begin
                out_prod <= prod_fin;
                out_acc  <= acc_nxt;
                out_ovf  <= out_ovf | ovf_now;
            end
        end
    end

endmodule
